// File: rtl/rv32i_rf_wb_arbiter.sv
// rv32i register-file writeback arbiter with pending-write scoreboard.
// Round-robin shares the single write port; the scoreboard flags RAW/WAW.
module rv32i_rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [4:0]              write_reg,
  output logic [XLEN-1:0]         write_data,
  output logic                    write_enable,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  output logic                    issue_ready,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  output logic                    hazard
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;

  // Round-robin search starting just above the last winner.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    xfer      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!xfer && req_valid[idx]) begin
        xfer           = 1'b1;
        req_ready[idx] = 1'b1;
        gnt_idx        = idx[PW-1:0];
      end
    end
  end

  assign sel_rd   = req_rd[int'(gnt_idx)*5 +: 5];
  assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

  // Registered write port; x0 writes complete the handshake silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= PW'(NUM_REQ - 1);
      write_reg    <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else if (xfer) begin
      rr_ptr       <= gnt_idx;
      write_reg    <= sel_rd;
      write_data   <= sel_data;
      write_enable <= (sel_rd != 5'd0);
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign issue_ready = ~pending[issue_rd];

  assign hazard = ((chk_rs1 != 5'd0) && pending[chk_rs1]) ||
                  ((chk_rs2 != 5'd0) && pending[chk_rs2]);

  // Release on committed write, reserve on accepted issue.
  always_comb begin
    pending_nxt = pending;
    if (write_enable)
      pending_nxt[write_reg] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0))
      pending_nxt[issue_rd] = 1'b1;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

endmodule

// File: tb/tb_rv32i_rf_wb_arbiter.sv
// Bench for rv32i_rf_wb_arbiter: vector table for arbitration,
// queue of expected writes, hand-written scoreboard/reset sequences.
module tb_rv32i_rf_wb_arbiter;

  localparam int N = 3;
  localparam int X = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*5-1:0] req_rd;
  logic [N*X-1:0] req_data;
  logic [4:0]     write_reg;
  logic [X-1:0]   write_data;
  logic           write_enable;
  logic           issue_valid;
  logic [4:0]     issue_rd;
  logic           issue_ready;
  logic [4:0]     chk_rs1;
  logic [4:0]     chk_rs2;
  logic           hazard;

  rv32i_rf_wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .write_reg(write_reg), .write_data(write_data),
    .write_enable(write_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*5-1:0] rd;
    logic [N*X-1:0] data;
    logic [N-1:0]   exp_ready;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         q[$];
  vec_t        tbl[12];
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  function automatic vec_t mk(
    input logic [2:0] v,
    input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
    input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
    input logic [2:0] er);
    vec_t t;
    t.valid = v;
    t.rd = {r2, r1, r0};
    t.data = {d2, d1, d0};
    t.exp_ready = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    wb_t e;
    int g;
    g = -1;
    req_valid = v.valid;
    req_rd = v.rd;
    req_data = v.data;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    for (int i = 0; i < N; i++)
      if (v.exp_ready[i] && v.valid[i]) g = i;
    e.we = 1'b0;
    if (g >= 0) begin
      last_rd = v.rd[g*5 +: 5];
      last_data = v.data[g*X +: X];
      e.we = (last_rd != 5'd0);
    end
    e.rd = last_rd;
    e.data = last_data;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("write_enable", 32'(write_enable), 32'(e.we));
    chk("write_reg", 32'(write_reg), 32'(e.rd));
    chk("write_data", write_data, e.data);
  endtask

  vec_t idle;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle = mk(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'b000);
    tbl[0]  = mk(3'b111, 5'd3, 5'd2, 5'd1, 32'hC, 32'hB, 32'hA, 3'b001);
    tbl[1]  = mk(3'b111, 5'd3, 5'd2, 5'd1, 32'hC, 32'hB, 32'hA, 3'b010);
    tbl[2]  = mk(3'b111, 5'd3, 5'd2, 5'd1, 32'hC, 32'hB, 32'hA, 3'b100);
    tbl[3]  = mk(3'b111, 5'd3, 5'd2, 5'd1, 32'hC, 32'hB, 32'hA, 3'b001);
    tbl[4]  = mk(3'b100, 5'd5, 5'd0, 5'd0, 32'h55, 0, 0, 3'b100);
    tbl[5]  = mk(3'b100, 5'd6, 5'd0, 5'd0, 32'h66, 0, 0, 3'b100);
    tbl[6]  = mk(3'b100, 5'd7, 5'd0, 5'd0, 32'h77, 0, 0, 3'b100);
    tbl[7]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'b000);
    tbl[8]  = mk(3'b001, 5'd0, 5'd0, 5'd0, 0, 0, 32'hDEADBEEF, 3'b001);
    tbl[9]  = mk(3'b111, 5'd12, 5'd11, 5'd10, 32'h12, 32'h11, 32'h10, 3'b010);
    tbl[10] = mk(3'b011, 5'd0, 5'd14, 5'd13, 0, 32'h14, 32'h13, 3'b001);
    tbl[11] = mk(3'b110, 5'd17, 5'd16, 5'd15, 32'h17, 32'h16, 32'h15, 3'b010);

    rst_n = 1'b0;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    chk_rs1 = '0;
    chk_rs2 = '0;
    last_rd = '0;
    last_data = '0;
    #3;
    chk("rst write_enable", 32'(write_enable), 0);
    chk("rst write_reg", 32'(write_reg), 0);
    chk("rst write_data", write_data, 0);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst hazard", 32'(hazard), 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) step(tbl[i]);
    step(idle);

    issue_valid = 1'b1;
    issue_rd = 5'd9;
    #1 chk("issue_ready 9 free", 32'(issue_ready), 1);
    step(idle);
    issue_valid = 1'b0;
    chk_rs1 = 5'd9;
    #1;
    chk("hazard rs1 9", 32'(hazard), 1);
    chk("waw block 9", 32'(issue_ready), 0);
    step(mk(3'b001, 5'd0, 5'd0, 5'd9, 0, 0, 32'h99, 3'b001));
    chk("hazard in we cycle", 32'(hazard), 1);
    step(idle);
    chk("hazard after clear", 32'(hazard), 0);
    chk("issue_ready 9 again", 32'(issue_ready), 1);

    chk_rs1 = 5'd0;
    issue_valid = 1'b1;
    for (int r = 1; r < 32; r++) begin
      issue_rd = 5'(r);
      step(idle);
    end
    issue_valid = 1'b0;
    chk_rs2 = 5'd0;
    #1 chk("hazard x0 all set", 32'(hazard), 0);
    chk_rs2 = 5'd31;
    #1 chk("hazard rs2 31", 32'(hazard), 1);
    issue_rd = 5'd5;
    #1 chk("waw block 5", 32'(issue_ready), 0);
    issue_rd = 5'd0;
    issue_valid = 1'b1;
    #1 chk("issue_ready x0", 32'(issue_ready), 1);
    step(idle);
    issue_valid = 1'b0;
    chk_rs2 = 5'd5;
    #1 chk("pending kept", 32'(hazard), 1);

    step(mk(3'b010, 5'd0, 5'd20, 5'd0, 0, 32'h20, 0, 3'b010));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst write_enable", 32'(write_enable), 0);
    chk("async rst write_reg", 32'(write_reg), 0);
    chk("async rst hazard", 32'(hazard), 0);
    last_rd = '0;
    last_data = '0;
    #1 rst_n = 1'b1;
    step(tbl[0]);
    step(tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_rf_wb_arbiter.md
Name: rv32i_rf_wb_arbiter

Overview:
- Shares the single write port of the rv32i register file between NUM_REQ writeback requesters (ALU, LSU, CSR/debug) using round-robin valid/ready arbitration with a registered output stage.
- Keeps a 32-entry pending-write scoreboard: issue reserves a destination, the committed write releases it.
- Gives issue a RAW hazard flag for rs1/rs2 and a WAW block.
- Sits between the execute/memory units and the register file write interface.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 wins first after reset.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester writeback valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_rd  input  NUM_REQ*5  destination register per requester; slice i at [5i+4:5i].
- req_data  input  NUM_REQ*XLEN  write data per requester; slice i at [XLEN*i+XLEN-1:XLEN*i].
- write_reg  output  5  to register file write_reg.
- write_data  output  XLEN  to register file write_data.
- write_enable  output  1  to register file write_enable.
- issue_valid  input  1  instruction issuing with a destination reservation.
- issue_rd  input  5  destination to reserve.
- issue_ready  output  1  reservation accepted this cycle.
- chk_rs1  input  5  source 1 of the instruction at issue.
- chk_rs2  input  5  source 2 of the instruction at issue.
- hazard  output  1  a source has an uncommitted pending write.

Behaviour:
- Reset (async, rst_n=0): write_enable=0, write_reg=0, write_data=0, pending[31:0]=0, rr_ptr=NUM_REQ-1. req_ready follows combinational logic from the reset state.
- Arbitration is combinational. The search starts at index (rr_ptr+1) mod NUM_REQ and moves upward with wrap. The first index with req_valid=1 gets req_ready=1; all others get 0. With no valid requests, req_ready=0.
- Transfer happens when req_valid[i] & req_ready[i] at a clock edge. rr_ptr updates to i only on a transfer; otherwise it holds.
- A requester keeps valid, rd and data stable until accepted. Deasserting valid before acceptance is legal and drops that request.
- Output stage has 1-cycle latency: at the transfer edge, write_reg<=req_rd[i], write_data<=req_data[i], write_enable<=(req_rd[i]!=0). With no transfer, write_enable<=0 and write_reg/write_data hold.
- Throughput is one write per cycle. A different or the same requester may win every cycle.
- rd=0 write is accepted (handshake completes, rr_ptr advances) but produces write_enable=0.
- Scoreboard set: at an edge with issue_valid & issue_ready & issue_rd!=0, pending[issue_rd]<=1.
- Scoreboard clear: at an edge with write_enable=1, pending[write_reg]<=0. The clear coincides with the register file capturing the data, so a combinational read is valid once hazard drops.
- issue_ready = !pending[issue_rd] (WAW block). issue_ready is 1 for issue_rd=0, and such an issue reserves nothing.
- hazard = (chk_rs1!=0 & pending[chk_rs1]) | (chk_rs2!=0 & pending[chk_rs2]). hazard is combinational on current pending, with no bypass of a same-cycle write.
- Same-edge set and clear on the same register cannot occur, because issue_ready=0 while the bit is set. Set and clear on different registers both apply.
- A writeback to a register with pending=0 is legal: it writes and the clear is a no-op.
- Reset mid-operation clears all state immediately, so an in-flight output write is lost (write_enable=0).

Test Plan:
- Reset, then req_valid=3'b111, rd={3,2,1}, data={C,B,A}. Required: grants 0,1,2,0 on consecutive cycles; write_enable=1 each following cycle; write_reg=1,2,3 with data A,B,C.
- Single requester 2 streaming rd=5,6,7 for 3 cycles. Required: req_ready[2]=1 every cycle; write_reg 5,6,7 back-to-back, each 1 cycle after its accept.
- Request with rd=0, data=32'hDEADBEEF. Required: req_ready=1, write_enable stays 0, and the next grant moves to the following index.
- issue rd=9; next cycle chk_rs1=9. Required: hazard=1 and issue_ready=0 for issue_rd=9. Then writeback rd=9. Required: hazard=1 through the write_enable cycle, hazard=0 in the cycle after; issue_rd=9 accepted again.
- chk_rs1=0, chk_rs2=0 with pending all set. Required: hazard=0. issue_rd=0 gives issue_ready=1 and pending unchanged.
- Assert rst_n=0 asynchronously mid-stream while write_enable=1. Required: write_enable=0 and pending=0 immediately, without waiting for clk; after release, the first grant goes to requester 0.
